instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 124 ++++++++++++
 tb/tb_instruction_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: internal loadable instruction memory, PC sequencing with
// stall/redirect handling, and an IDLE/RUN/HALT control FSM that stops on HALT_WORD.
module instruction_fetch #(
   parameter int                 NB_DATA   = 32,
   parameter int                 NB_ADDR   = 8,
   parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_stall,
   input  logic               i_jump,
   input  logic [NB_DATA-1:0] i_jump_addr,
   input  logic               i_inst_we,
   input  logic [NB_ADDR-1:0] i_inst_addr,
   input  logic [NB_DATA-1:0] i_inst_data,
   output logic [NB_DATA-1:0] o_instruction,
   output logic [NB_DATA-1:0] o_pcounter4,
   output logic [NB_DATA-1:0] o_pc,
   output logic               o_valid,
   output logic               o_halt,
   output logic [1:0]         o_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [NB_DATA-1:0] PC_STEP  = NB_DATA'(4);
   localparam logic [NB_DATA-1:0] ALIGN_MASK = ~NB_DATA'(3);

   logic [NB_DATA-1:0] mem_q [0:(1<<NB_ADDR)-1];

   logic [1:0]         state_q, state_d;
   logic [NB_DATA-1:0] pc_q, pc_d;
   logic [NB_DATA-1:0] instr_q, instr_d;
   logic [NB_DATA-1:0] pc4_q, pc4_d;
   logic               valid_q, valid_d;
   logic               halt_q, halt_d;

   logic [NB_DATA-1:0] fetch_word;
   logic [NB_DATA-1:0] pc_plus4;
   logic [NB_DATA-1:0] jump_pc;

   // Word index taken from the byte PC; upper PC bits alias, so fetch wraps around memory.
   assign fetch_word = mem_q[pc_q[NB_ADDR+1:2]];
   assign pc_plus4   = pc_q + PC_STEP;
   assign jump_pc    = i_jump_addr & ALIGN_MASK;

   // Loader port is only live while idle; memory is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if ((state_q == ST_IDLE) && i_inst_we) begin
         mem_q[i_inst_addr] <= i_inst_data;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      halt_d  = halt_q;
      case (state_q)
         ST_IDLE: begin
            pc_d    = '0;
            instr_d = '0;
            valid_d = 1'b0;
            if (i_start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Redirect wins over stall: the wrong-path word is replaced by a bubble.
            if (i_jump) begin
               pc_d    = jump_pc;
               instr_d = '0;
               valid_d = 1'b0;
            end else if (!i_stall) begin
               instr_d = fetch_word;
               pc4_d   = pc_plus4;
               valid_d = 1'b1;
               if (fetch_word == HALT_WORD) begin
                  halt_d  = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  pc_d = pc_plus4;
               end
            end
         end
         ST_HALT: begin
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         halt_q  <= halt_d;
      end
   end

   assign o_instruction = instr_q;
   assign o_pcounter4   = pc4_q;
   assign o_pc          = pc_q;
   assign o_valid       = valid_q;
   assign o_halt        = halt_q;
   assign o_state       = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized and directed bench for instruction_fetch against a cycle-level
// behavioural model of the fetch rules.
module tb_instruction_fetch;

   localparam int          NB_DATA = 32;
   localparam int          NB_ADDR = 8;
   localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0, start = 1'b0, stall = 1'b0, jump = 1'b0, we = 1'b0;
   logic [31:0] jaddr = '0, idata = '0;
   logic [7:0]  iaddr = '0;
   logic [31:0] o_instruction, o_pcounter4, o_pc;
   logic        o_valid, o_halt;
   logic [1:0]  o_state;

   int n_vec = 0;
   int n_err = 0;

   // Model state: mode 0 idle, 1 running, 2 halted.
   int          m_mode = 0;
   logic [31:0] m_pc = '0, m_ins = '0, m_pc4 = '0;
   logic        m_vld = 1'b0, m_hlt = 1'b0;
   logic [31:0] m_mem [256];

   instruction_fetch #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .HALT_WORD(HALT)) dut (
      .clk          (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_stall      (stall),
      .i_jump       (jump),
      .i_jump_addr  (jaddr),
      .i_inst_we    (we),
      .i_inst_addr  (iaddr),
      .i_inst_data  (idata),
      .o_instruction(o_instruction),
      .o_pcounter4  (o_pcounter4),
      .o_pc         (o_pc),
      .o_valid      (o_valid),
      .o_halt       (o_halt),
      .o_state      (o_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [31:0] w;
      if (rst) begin
         m_mode = 0; m_pc = '0; m_ins = '0; m_pc4 = '0; m_vld = 1'b0; m_hlt = 1'b0;
      end else if (m_mode == 0) begin
         if (we) m_mem[iaddr] = idata;
         m_pc = '0; m_ins = '0; m_vld = 1'b0;
         if (start) m_mode = 1;
      end else if (m_mode == 1) begin
         if (jump) begin
            m_pc  = {jaddr[31:2], 2'b00};
            m_ins = '0;
            m_vld = 1'b0;
         end else if (!stall) begin
            w     = m_mem[(m_pc / 4) % 256];
            m_ins = w;
            m_pc4 = m_pc + 4;
            m_vld = 1'b1;
            if (w == HALT) begin
               m_hlt  = 1'b1;
               m_mode = 2;
            end else begin
               m_pc = m_pc + 4;
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("instruction", o_instruction, m_ins);
      chk("pcounter4", o_pcounter4, m_pc4);
      chk("pc", o_pc, m_pc);
      chk("valid", 32'(o_valid), 32'(m_vld));
      chk("halt", 32'(o_halt), 32'(m_hlt));
      chk("state", 32'(o_state), 32'(m_mode));
   endtask

   task automatic idle_inputs();
      rst = 1'b0; start = 1'b0; stall = 1'b0; jump = 1'b0; we = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic load(input logic [7:0] a, input logic [31:0] d);
      we = 1'b1; iaddr = a; idata = d;
      cycle();
      we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(15) == 0) w = HALT;
      else if (w == HALT) w = 32'h0;
      return w;
   endfunction

   initial begin
      // Reset and full memory initialisation.
      do_reset();
      chk("rst_instruction", o_instruction, 32'h0);
      chk("rst_state", 32'(o_state), 32'd0);
      for (int a = 0; a < 256; a++) begin
         load(8'(a), (a < 8) ? 32'h0100_0000 + 32'(a) : rand_word());
      end

      // Basic program ending on HALT_WORD.
      load(8'd0, 32'h2001_0004);
      load(8'd1, 32'h0022_1821);
      load(8'd2, HALT);
      pulse_start();
      cycle();
      chk("p1_ins0", o_instruction, 32'h2001_0004);
      chk("p1_pc4_0", o_pcounter4, 32'd4);
      cycle();
      chk("p1_ins1", o_instruction, 32'h0022_1821);
      chk("p1_pc4_1", o_pcounter4, 32'd8);
      cycle();
      chk("p1_ins2", o_instruction, HALT);
      chk("p1_pc4_2", o_pcounter4, 32'd12);
      chk("p1_halt", 32'(o_halt), 32'd1);
      chk("p1_state", 32'(o_state), 32'd2);

      // Everything ignored in HALT, then reset and refetch with memory intact.
      start = 1'b1; jump = 1'b1; jaddr = 32'h40; stall = 1'b1;
      we = 1'b1; iaddr = 8'd0; idata = 32'hDEAD_0000;
      cycle(); cycle();
      idle_inputs();
      chk("halt_hold_pc", o_pc, 32'd8);
      rst = 1'b1; start = 1'b1;
      cycle();
      idle_inputs();
      chk("hrst_state", 32'(o_state), 32'd0);
      chk("hrst_ins", o_instruction, 32'h0);
      chk("hrst_halt", 32'(o_halt), 32'd0);
      cycle();
      chk("hrst_start_ignored", 32'(o_state), 32'd0);
      pulse_start();
      cycle();
      chk("refetch_ins0", o_instruction, 32'h2001_0004);

      // Loader write during RUN must not land.
      we = 1'b1; iaddr = 8'd1; idata = 32'hBAD0_BAD0;
      cycle();
      we = 1'b0;
      do_reset();
      pulse_start();
      cycle(); cycle();
      chk("we_in_run_ignored", o_instruction, 32'h0022_1821);

      // Stall at PC=8.
      do_reset();
      load(8'd2, 32'h0A0A_0A0A);
      load(8'd3, HALT);
      pulse_start();
      cycle(); cycle();
      chk("pre_stall_pc", o_pc, 32'd8);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_pc", o_pc, 32'd8);
         chk("stall_ins", o_instruction, 32'h0022_1821);
         chk("stall_pc4", o_pcounter4, 32'd8);
      end
      stall = 1'b0;
      cycle();
      chk("post_stall_ins", o_instruction, 32'h0A0A_0A0A);

      // Jump with unaligned target from PC=4.
      do_reset();
      load(8'd4, 32'h4444_4444);
      load(8'd5, HALT);
      pulse_start();
      cycle();
      chk("pre_jump_pc", o_pc, 32'd4);
      jump = 1'b1; jaddr = 32'h13;
      cycle();
      jump = 1'b0;
      chk("jump_ins", o_instruction, 32'h0);
      chk("jump_valid", 32'(o_valid), 32'd0);
      chk("jump_pc", o_pc, 32'h10);
      cycle();
      chk("jump_tgt_ins", o_instruction, 32'h4444_4444);
      chk("jump_tgt_pc4", o_pcounter4, 32'h14);

      // Jump and stall together: redirect wins.
      do_reset();
      pulse_start();
      cycle();
      jump = 1'b1; stall = 1'b1; jaddr = 32'h8;
      cycle();
      idle_inputs();
      chk("js_valid", 32'(o_valid), 32'd0);
      chk("js_pc", o_pc, 32'h8);

      // Same-cycle start and load in IDLE.
      do_reset();
      start = 1'b1; we = 1'b1; iaddr = 8'd0; idata = 32'h3131_3131;
      cycle();
      idle_inputs();
      cycle();
      chk("start_we_ins", o_instruction, 32'h3131_3131);

      // Randomized runs, including wrap-around jump targets and mid-run resets.
      for (int r = 0; r < 10; r++) begin
         do_reset();
         for (int k = 0; k < 16; k++) load(8'($urandom_range(255)), rand_word());
         pulse_start();
         for (int c = 0; c < 60; c++) begin
            stall = ($urandom_range(4) == 0);
            jump  = ($urandom_range(7) == 0);
            case ($urandom_range(3))
               0:       jaddr = 32'h0000_03FC | 32'($urandom_range(3));
               1:       jaddr = 32'hFFFF_FFFC | 32'($urandom_range(3));
               default: jaddr = $urandom;
            endcase
            we    = ($urandom_range(7) == 0);
            iaddr = 8'($urandom_range(255));
            idata = rand_word();
            start = ($urandom_range(15) == 0);
            rst   = ($urandom_range(49) == 0);
            if (rst) we = 1'b0;
            cycle();
         end
         idle_inputs();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
